// File: rtl/conv_window_sequencer.sv
// +----------------------------------------------------------------------------+
// | conv_window_sequencer: issues per-lane data/filter element addresses for   |
// | every convolution window in row-major order.                     rev 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module conv_window_sequencer #(
    parameter int VECTOR_SIZE = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int DIM_WIDTH   = 8
) (
    input  logic                              clkIn,
    input  logic                              rstIn,
    input  logic                              startIn,
    input  logic [DIM_WIDTH-1:0]              filtRowsIn,
    input  logic [DIM_WIDTH-1:0]              filtColsIn,
    input  logic [DIM_WIDTH-1:0]              dataRowsIn,
    input  logic [DIM_WIDTH-1:0]              dataColsIn,
    input  logic [DIM_WIDTH-1:0]              strideIn,
    input  logic                              readyIn,
    output logic                              validOut,
    output logic [VECTOR_SIZE-1:0]            laneValidOut,
    output logic [VECTOR_SIZE*ADDR_WIDTH-1:0] dataAddrOut,
    output logic [VECTOR_SIZE*ADDR_WIDTH-1:0] filtAddrOut,
    output logic                              lastOut,
    output logic                              busyOut,
    output logic                              doneOut,
    output logic                              errOut
);

    localparam int AW1  = ADDR_WIDTH + 1;
    localparam int PW   = 2 * DIM_WIDTH;
    localparam int KW   = PW + $clog2(VECTOR_SIZE) + 1;
    localparam int CMPW = PW + AW1;
    localparam int SW   = DIM_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Captured job configuration
    logic [DIM_WIDTH-1:0] filt_rows, filt_cols, data_rows, data_cols, stride;
    logic [PW-1:0]        f_total;
    logic [AW1-1:0]       row_step;

    // Window origin (in elements) and beat position of lane 0
    logic [SW-1:0]        win_col, win_row;
    logic [AW1-1:0]       win_row_addr;
    logic [KW-1:0]        beat_k;
    logic [DIM_WIDTH-1:0] base_col;
    logic [AW1-1:0]       base_roff;
    logic                 err_pulse;

    logic [PW-1:0]        area_in, step_in, filt_in;
    logic                 cfg_bad, start_ok, start_bad, fire;
    logic [KW-1:0]        beat_next_k;
    logic                 last_beat, col_fits, row_fits, last_window;

    logic [DIM_WIDTH-1:0] lane_col  [VECTOR_SIZE+1];
    logic [AW1-1:0]       lane_roff [VECTOR_SIZE+1];

    assign area_in = PW'(dataRowsIn) * PW'(dataColsIn);
    assign step_in = PW'(strideIn) * PW'(dataColsIn);
    assign filt_in = PW'(filtRowsIn) * PW'(filtColsIn);

    assign cfg_bad = (filtRowsIn == '0) || (filtColsIn == '0) || (dataRowsIn == '0) ||
                     (dataColsIn == '0) || (strideIn == '0) ||
                     (filtRowsIn > dataRowsIn) || (filtColsIn > dataColsIn) ||
                     (CMPW'(area_in) > (CMPW'(1) << ADDR_WIDTH));

    assign start_ok  = (state == IDLE) && startIn && !cfg_bad;
    assign start_bad = (state == IDLE) && startIn && cfg_bad;

    assign validOut = (state == RUN);
    assign busyOut  = (state != IDLE);
    assign doneOut  = (state == DONE);
    assign errOut   = err_pulse;
    assign fire     = validOut && readyIn;

    assign beat_next_k = beat_k + KW'(VECTOR_SIZE);
    assign last_beat   = (beat_next_k >= KW'(f_total));
    assign lastOut     = validOut && last_beat;

    // A further window exists along an axis when its origin plus filter still fits
    assign col_fits    = (win_col + SW'(stride) + SW'(filt_cols)) <= SW'(data_cols);
    assign row_fits    = (win_row + SW'(stride) + SW'(filt_rows)) <= SW'(data_rows);
    assign last_window = !col_fits && !row_fits;

    // Walk the filter (row, col) position across the lanes; entry VECTOR_SIZE
    // is where the next beat's lane 0 starts.
    always_comb begin
        lane_col[0]  = base_col;
        lane_roff[0] = base_roff;
        for (int i = 1; i <= VECTOR_SIZE; i++) begin
            if (lane_col[i-1] == filt_cols - DIM_WIDTH'(1)) begin
                lane_col[i]  = '0;
                lane_roff[i] = lane_roff[i-1] + AW1'(data_cols);
            end else begin
                lane_col[i]  = lane_col[i-1] + DIM_WIDTH'(1);
                lane_roff[i] = lane_roff[i-1];
            end
        end
    end

    always_comb begin
        laneValidOut = '0;
        dataAddrOut  = '0;
        filtAddrOut  = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (validOut && ((beat_k + KW'(i)) < KW'(f_total))) begin
                laneValidOut[i] = 1'b1;
                filtAddrOut[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(beat_k + KW'(i));
                dataAddrOut[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    ADDR_WIDTH'(win_row_addr + AW1'(win_col) + lane_roff[i] + AW1'(lane_col[i]));
            end
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (fire && last_beat && last_window) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            filt_rows    <= '0;
            filt_cols    <= '0;
            data_rows    <= '0;
            data_cols    <= '0;
            stride       <= '0;
            f_total      <= '0;
            row_step     <= '0;
            win_col      <= '0;
            win_row      <= '0;
            win_row_addr <= '0;
            beat_k       <= '0;
            base_col     <= '0;
            base_roff    <= '0;
            err_pulse    <= 1'b0;
        end else begin
            err_pulse <= start_bad;
            if (start_ok) begin
                filt_rows    <= filtRowsIn;
                filt_cols    <= filtColsIn;
                data_rows    <= dataRowsIn;
                data_cols    <= dataColsIn;
                stride       <= strideIn;
                f_total      <= filt_in;
                row_step     <= AW1'(step_in);
                win_col      <= '0;
                win_row      <= '0;
                win_row_addr <= '0;
                beat_k       <= '0;
                base_col     <= '0;
                base_roff    <= '0;
            end else if (fire) begin
                if (!last_beat) begin
                    beat_k    <= beat_next_k;
                    base_col  <= lane_col[VECTOR_SIZE];
                    base_roff <= lane_roff[VECTOR_SIZE];
                end else begin
                    beat_k    <= '0;
                    base_col  <= '0;
                    base_roff <= '0;
                    if (col_fits) begin
                        win_col <= win_col + SW'(stride);
                    end else begin
                        win_col      <= '0;
                        win_row      <= win_row + SW'(stride);
                        win_row_addr <= win_row_addr + row_step;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: reference beat lists built from the window
// arithmetic, compared against the DUT on every presented beat.
`default_nettype none

module tb_conv_window_sequencer;

    localparam int V  = 8;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int CW = V * AW;

    logic           clkIn = 1'b0;
    logic           rstIn, startIn, readyIn;
    logic [DW-1:0]  filtRowsIn, filtColsIn, dataRowsIn, dataColsIn, strideIn;
    logic           validOut, lastOut, busyOut, doneOut, errOut;
    logic [V-1:0]   laneValidOut;
    logic [CW-1:0]  dataAddrOut, filtAddrOut;

    conv_window_sequencer #(.VECTOR_SIZE(V), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn),
        .filtRowsIn(filtRowsIn), .filtColsIn(filtColsIn),
        .dataRowsIn(dataRowsIn), .dataColsIn(dataColsIn), .strideIn(strideIn),
        .readyIn(readyIn), .validOut(validOut), .laneValidOut(laneValidOut),
        .dataAddrOut(dataAddrOut), .filtAddrOut(filtAddrOut), .lastOut(lastOut),
        .busyOut(busyOut), .doneOut(doneOut), .errOut(errOut)
    );

    always #5 clkIn = ~clkIn;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [V-1:0]  exp_lv [$];
    logic [CW-1:0] exp_da [$];
    logic [CW-1:0] exp_fa [$];
    logic          exp_last [$];

    int  exp_idx  = 0;
    int  done_cnt = 0;
    bit  chk_en = 0, last_acc = 0, after_done = 0, stalled = 0;
    logic [V-1:0]  snap_lv;
    logic [CW-1:0] snap_da, snap_fa;
    logic          snap_last;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected beats straight from the window arithmetic
    task automatic build_model(input int fr, input int fc, input int dr, input int dc, input int s);
        int orows, ocols, f, nb, k;
        logic [V-1:0]  lv;
        logic [CW-1:0] da, fa;
        exp_lv.delete(); exp_da.delete(); exp_fa.delete(); exp_last.delete();
        orows = (dr - fr) / s + 1;
        ocols = (dc - fc) / s + 1;
        f     = fr * fc;
        nb    = (f + V - 1) / V;
        for (int oy = 0; oy < orows; oy++)
            for (int ox = 0; ox < ocols; ox++)
                for (int b = 0; b < nb; b++) begin
                    lv = '0; da = '0; fa = '0;
                    for (int i = 0; i < V; i++) begin
                        k = b * V + i;
                        if (k < f) begin
                            lv[i] = 1'b1;
                            fa[i*AW +: AW] = AW'(k);
                            da[i*AW +: AW] = AW'((oy * s + k / fc) * dc + ox * s + k % fc);
                        end
                    end
                    exp_lv.push_back(lv);
                    exp_da.push_back(da);
                    exp_fa.push_back(fa);
                    exp_last.push_back(b == nb - 1);
                end
        exp_idx = 0;
    endtask

    initial begin
        forever begin
            @(negedge clkIn);
            if (chk_en) begin
                if (last_acc) begin
                    chk("done_pulse", CW'(doneOut), CW'(1));
                    chk("done_valid_low", CW'(validOut), CW'(0));
                    chk("done_busy", CW'(busyOut), CW'(1));
                    last_acc   = 0;
                    after_done = 1;
                end else if (after_done) begin
                    chk("post_done_idle", CW'({doneOut, busyOut}), CW'(0));
                    after_done = 0;
                end else if (doneOut) begin
                    chk("spurious_done", CW'(doneOut), CW'(0));
                end
                if (doneOut) done_cnt++;
                if (stalled) begin
                    chk("stall_valid", CW'(validOut), CW'(1));
                    chk("stall_lv", CW'(laneValidOut), CW'(snap_lv));
                    chk("stall_data", dataAddrOut, snap_da);
                    chk("stall_filt", filtAddrOut, snap_fa);
                    chk("stall_last", CW'(lastOut), CW'(snap_last));
                end
                if (validOut) begin
                    if (exp_idx >= exp_lv.size()) begin
                        chk("extra_beat", CW'(exp_idx), CW'(exp_lv.size()));
                    end else begin
                        chk("lane_valid", CW'(laneValidOut), CW'(exp_lv[exp_idx]));
                        chk("data_addr", dataAddrOut, exp_da[exp_idx]);
                        chk("filt_addr", filtAddrOut, exp_fa[exp_idx]);
                        chk("last", CW'(lastOut), CW'(exp_last[exp_idx]));
                        chk("busy_run", CW'({busyOut, errOut}), CW'(2));
                    end
                    stalled   = !readyIn;
                    snap_lv   = laneValidOut;
                    snap_da   = dataAddrOut;
                    snap_fa   = filtAddrOut;
                    snap_last = lastOut;
                    if (readyIn) begin
                        if (exp_idx == exp_lv.size() - 1) last_acc = 1;
                        exp_idx++;
                    end
                end else begin
                    stalled = 0;
                end
            end
        end
    end

    task automatic set_dims(input int fr, input int fc, input int dr, input int dc, input int s);
        filtRowsIn = DW'(fr); filtColsIn = DW'(fc);
        dataRowsIn = DW'(dr); dataColsIn = DW'(dc); strideIn = DW'(s);
    endtask

    // Entered and left just after a rising edge
    task automatic run_job(input int fr, input int fc, input int dr, input int dc, input int s,
                           input int stall_at, input int toggle, input int start_at,
                           input int rst_beat);
        int cyc;
        bit aborted;
        build_model(fr, fc, dr, dc, s);
        done_cnt = 0;
        set_dims(fr, fc, dr, dc, s);
        startIn = 1'b1;
        readyIn = 1'b1;
        cyc = 0;
        aborted = 0;
        while (done_cnt == 0 && cyc < 500) begin
            @(posedge clkIn); #1;
            if (cyc == 0) chk("first_beat_latency", CW'(validOut), CW'(1));
            startIn = (cyc == start_at);
            if (cyc == start_at) set_dims(1, 1, 2, 2, 1);
            else set_dims(fr, fc, dr, dc, s);
            readyIn = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3) &&
                      !(toggle != 0 && cyc % 3 == 1);
            if (rst_beat >= 0 && validOut && exp_idx == rst_beat) begin
                chk_en = 0;
                #2 rstIn = 1'b0;
                #1;
                chk("rst_valid", CW'(validOut), CW'(0));
                chk("rst_lv", CW'(laneValidOut), CW'(0));
                chk("rst_data", dataAddrOut, CW'(0));
                chk("rst_filt", filtAddrOut, CW'(0));
                chk("rst_flags", CW'({lastOut, busyOut, doneOut, errOut}), CW'(0));
                repeat (2) begin
                    @(negedge clkIn);
                    chk("rst_no_done", CW'({doneOut, validOut}), CW'(0));
                end
                @(posedge clkIn); #1;
                rstIn = 1'b1;
                startIn = 1'b0;
                readyIn = 1'b1;
                last_acc = 0; after_done = 0; stalled = 0;
                chk_en = 1;
                aborted = 1;
                break;
            end
            cyc++;
        end
        if (!aborted) begin
            chk("job_done_seen", CW'(done_cnt), CW'(1));
            chk("beat_count", CW'(exp_idx), CW'(exp_lv.size()));
        end
    endtask

    task automatic err_job(input int fr, input int fc, input int dr, input int dc, input int s);
        set_dims(fr, fc, dr, dc, s);
        startIn = 1'b1;
        @(posedge clkIn); #1;
        startIn = 1'b0;
        chk("err_pulse", CW'(errOut), CW'(1));
        chk("err_no_run", CW'({validOut, busyOut}), CW'(0));
        @(posedge clkIn); #1;
        chk("err_one_cycle", CW'(errOut), CW'(0));
        chk("err_still_idle", CW'({validOut, busyOut}), CW'(0));
    endtask

    initial begin
        rstIn = 1'b0; startIn = 1'b0; readyIn = 1'b0;
        set_dims(0, 0, 0, 0, 0);
        #2;
        chk("reset_valid", CW'(validOut), CW'(0));
        chk("reset_lv", CW'(laneValidOut), CW'(0));
        chk("reset_data", dataAddrOut, CW'(0));
        chk("reset_filt", filtAddrOut, CW'(0));
        chk("reset_flags", CW'({lastOut, busyOut, doneOut, errOut}), CW'(0));
        repeat (2) @(posedge clkIn);
        #1 rstIn = 1'b1;
        chk_en = 1;

        // 3x3 filter on 4x4 data, stride 1
        build_model(3, 3, 4, 4, 1);
        chk("model_a_beats", CW'(exp_lv.size()), CW'(8));
        chk("model_a_b0_data", exp_da[0],
            CW'({12'd9, 12'd8, 12'd6, 12'd5, 12'd4, 12'd2, 12'd1, 12'd0}));
        chk("model_a_b1_lv", CW'(exp_lv[1]), CW'(8'h01));
        chk("model_a_b1_lane0", CW'(exp_da[1][AW-1:0]), CW'(10));
        chk("model_a_b1_filt", CW'(exp_fa[1][AW-1:0]), CW'(8));
        chk("model_a_b1_last", CW'({exp_last[1], exp_last[0]}), CW'(2'b10));
        chk("model_a_b2_lane0", CW'(exp_da[2][AW-1:0]), CW'(1));
        run_job(3, 3, 4, 4, 1, -1, 0, -1, -1);

        // 2x2 filter on 4x4 data, stride 2
        build_model(2, 2, 4, 4, 2);
        chk("model_b_beats", CW'(exp_lv.size()), CW'(4));
        chk("model_b_w11_lv", CW'(exp_lv[3]), CW'(8'h0F));
        chk("model_b_w11_data", exp_da[3], CW'({12'd15, 12'd14, 12'd11, 12'd10}));
        run_job(2, 2, 4, 4, 2, -1, 0, -1, -1);

        // Back-pressure for 3 cycles on the second beat of a window
        run_job(3, 3, 4, 4, 1, 3, 0, -1, -1);

        // Rejected configurations
        err_job(5, 3, 4, 4, 1);
        err_job(3, 3, 4, 4, 0);
        err_job(1, 1, 65, 64, 1);

        // Smallest job
        build_model(1, 1, 1, 1, 1);
        chk("model_1x1", CW'({exp_lv.size() == 1, exp_lv[0], exp_last[0]}), CW'({1'b1, 8'h01, 1'b1}));
        chk("model_1x1_addr", exp_da[0] | exp_fa[0], CW'(0));
        run_job(1, 1, 1, 1, 1, -1, 0, -1, -1);

        // Uneven shapes with irregular readiness
        run_job(2, 3, 5, 7, 2, -1, 1, -1, -1);
        run_job(3, 4, 6, 9, 3, -1, 1, -1, -1);

        // Reset during beat 3, then a full fresh run
        run_job(3, 3, 4, 4, 1, -1, 0, -1, 3);
        run_job(3, 3, 4, 4, 1, -1, 0, -1, -1);

        // Start pulse while running is ignored
        run_job(3, 3, 4, 4, 1, -1, 0, 4, -1);

        repeat (3) @(posedge clkIn);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter VECTOR_SIZE, default 8, the number of lanes issued per beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, the element-address width per lane.
REQ-003 SHALL have parameter DIM_WIDTH, default 8, the width of each dimension and stride input.
REQ-004 SHALL have port clkIn, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rstIn, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 SHALL have port startIn, input, 1 bit, a one-cycle request to begin a job.
REQ-007 SHALL have ports filtRowsIn, filtColsIn, dataRowsIn and dataColsIn, inputs, DIM_WIDTH each, the job dimensions, sampled only when start is accepted.
REQ-008 SHALL have port strideIn, input, DIM_WIDTH, the window step in both axes, sampled only when start is accepted.
REQ-009 SHALL have port readyIn, input, 1 bit, the downstream acceptance signal.
REQ-010 SHALL have port validOut, output, 1 bit, indicating a beat is presented.
REQ-011 SHALL have port laneValidOut, output, VECTOR_SIZE bits, the per-lane valid mask.
REQ-012 SHALL have port dataAddrOut, output, VECTOR_SIZE*ADDR_WIDTH bits, the data-matrix element address per lane; lane i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-013 SHALL have port filtAddrOut, output, VECTOR_SIZE*ADDR_WIDTH bits, the filter element address per lane, packed the same way as dataAddrOut.
REQ-014 SHALL have port lastOut, output, 1 bit, marking the final beat of a window.
REQ-015 SHALL have ports busyOut, doneOut and errOut, outputs, 1 bit each: busyOut is high while a job runs; doneOut and errOut are one-cycle pulses.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 SHALL treat start as accepted when startIn=1 in IDLE; startIn in RUN or DONE SHALL be ignored.
REQ-018 SHALL reject a start, stay in IDLE and pulse errOut for 1 cycle (the cycle after start) when any of the following holds:
- any dimension or the stride is 0;
- filtRows > dataRows or filtCols > dataCols;
- dataRows*dataCols > 2^ADDR_WIDTH.
REQ-019 SHALL otherwise capture the configuration, enter RUN, and present the first beat with validOut=1 on the cycle after start.
REQ-020 SHALL compute the output size as outRows=(dataRows-filtRows)/stride+1 and outCols=(dataCols-filtCols)/stride+1, using floor division.
REQ-021 SHALL visit windows in row-major order (oy outer, ox inner), with F=filtRows*filtCols elements per window and ceil(F/VECTOR_SIZE) beats per window.
REQ-022 SHALL drive lane i of beat b as follows, with k=b*VECTOR_SIZE+i:
- laneValid = (k<F);
- filtAddr = k;
- dataAddr = (oy*stride + k/filtCols)*dataCols + ox*stride + k%filtCols.
REQ-023 SHALL drive dataAddr and filtAddr to 0 on invalid lanes.
REQ-024 SHALL assert lastOut together with the final beat of each window.
REQ-025 SHALL generate lane row and column positions with incremental counters; no runtime divider or modulo hardware is permitted.
REQ-026 SHALL hold validOut, laneValidOut, all addresses and lastOut stable while validOut=1 and readyIn=0.
REQ-027 SHALL advance on a cycle with validOut=1 and readyIn=1, and present the next beat on the following cycle with no bubble.
REQ-028 SHALL, on acceptance of the last beat of the last window, enter DONE, deassert validOut, pulse doneOut for 1 cycle, and then return to IDLE.
REQ-029 SHALL hold busyOut=1 in RUN and DONE only.
REQ-030 SHALL accept a new start in the cycle after DONE.
REQ-031 SHALL ensure a 1x1 data matrix with a 1x1 filter yields exactly 1 beat, with laneValidOut=1, lastOut=1 and all addresses 0.

Reset
REQ-032 SHALL, when rstIn=0, immediately clear all state and drive all outputs to 0, regardless of clock; the FSM SHALL return to IDLE.
REQ-033 SHALL, when reset is asserted mid-job, abandon the job with no doneOut; the first start after release SHALL begin a fresh job.

Verification
REQ-034 SHALL cover, with VECTOR_SIZE=8, a 3x3 filter on 4x4 data with stride 1 and readyIn=1 -> 8 beats:
- beat 0: dataAddr 0,1,2,4,5,6,8,9, laneValid 0xFF, last=0;
- beat 1: lane0 dataAddr 10, filtAddr 8, laneValid 0x01, last=1;
- beat 2: dataAddr starts at 1;
- doneOut 1 cycle after beat 7 is accepted.
REQ-035 SHALL cover a 2x2 filter on 4x4 data with stride 2 -> 4 beats, each with laneValid 0x0F and last=1; window (1,1) gives dataAddr 10,11,14,15.
REQ-036 SHALL cover holding readyIn=0 for 3 cycles mid-window -> every output is bit-identical across those cycles, and no beat is skipped or duplicated.
REQ-037 SHALL cover start with filtRows=5 and dataRows=4, and separately start with strideIn=0 -> errOut pulses for 1 cycle, with no validOut and no busyOut.
REQ-038 SHALL cover asserting rstIn=0 during beat 3 of the REQ-034 job -> outputs are 0 immediately, there is no doneOut, and a restart reproduces the REQ-034 sequence from beat 0.
REQ-039 SHALL cover startIn pulsed during RUN -> ignored, and the beat count is unchanged.
